config_shifter: RTL and testbench

- Byte-to-bit-serial loader for the configuration shift chain of connection/logic blocks.
- Sits between the UART byte stream and the chain's CE/SIN/SOUT pins.
- Each accepted byte is shifted into the chain LSB-first over 8 consecutive CE cycles.
- The 8 bits falling out of the chain tail are captured into a readback byte returned over a valid/ready port.

---
 rtl/config_pkg.sv | 14 +
 rtl/config_bit_counter.sv | 35 +++
 rtl/config_shifter.sv | 146 ++++++++++++++
 tb/tb_config_shifter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types and constants for the configuration chain byte loader.
package config_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BIT_IDX_W     = $clog2(BYTE_W);
    localparam int unsigned CHAIN_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/config_bit_counter.sv
// Saturating count of bits pushed into the chain; clear wins over a coincident shift.
module config_bit_counter #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          shift,
    output logic [CW-1:0] count,
    output logic          loaded
);

    logic [CW-1:0] count_n;

    always_comb begin
        count_n = count;
        if (clear) begin
            count_n = '0;
        end else if (shift && (count != CW'(CHAIN_LEN))) begin
            count_n = count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            loaded <= 1'b0;
        end else begin
            count  <= count_n;
            loaded <= (count_n == CW'(CHAIN_LEN));
        end
    end

endmodule

// File: rtl/config_shifter.sv
// Byte-to-serial loader for the configuration shift chain, with optional tail readback.
// Readback path (RESP state, DOUT_*, SHIFT_TAIL capture) exists only with CONFIG_SHIFTER_READBACK_EN.
module config_shifter
    import config_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    localparam int unsigned CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              DIN_VALID,
    input  logic [BYTE_W-1:0] DIN_DATA,
    output logic              DIN_READY,
    output logic              DOUT_VALID,
    output logic [BYTE_W-1:0] DOUT_DATA,
    input  logic              DOUT_READY,
    output logic              SHIFT_ENABLE,
    output logic              SHIFT_HEAD,
    input  logic              SHIFT_TAIL,
    input  logic              CLEAR,
    output logic [CW-1:0]     BIT_COUNT,
    output logic              CHAIN_LOADED
);

    state_t                 state, state_n;
    logic [BYTE_W-1:0]      sreg, sreg_n;
    logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
    logic                   din_ready, din_ready_n;
    logic                   shift_en, shift_en_n;
    logic                   head, head_n;
    logic                   tail_in;
    logic                   dout_valid_n;
    logic [BYTE_W-1:0]      dout_data_n;

`ifdef CONFIG_SHIFTER_READBACK_EN
    assign tail_in = SHIFT_TAIL;
`else
    logic unused_tail;
    logic unused_dout_ready;
    assign tail_in           = 1'b0;
    assign unused_tail       = SHIFT_TAIL;
    assign unused_dout_ready = DOUT_READY;
`endif

    // Next state plus registered-output values derived from the next state
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        bit_idx_n = bit_idx;

        case (state)
            ST_IDLE: begin
                if (DIN_VALID && din_ready) begin
                    sreg_n    = DIN_DATA;
                    bit_idx_n = '0;
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_n    = {tail_in, sreg[BYTE_W-1:1]};
                bit_idx_n = bit_idx + BIT_IDX_W'(1);
                if (bit_idx == BIT_IDX_W'(BYTE_W - 1)) begin
`ifdef CONFIG_SHIFTER_READBACK_EN
                    state_n = ST_RESP;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef CONFIG_SHIFTER_READBACK_EN
            ST_RESP: begin
                if (DOUT_READY) begin
                    state_n = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        din_ready_n  = (state_n == ST_IDLE);
        shift_en_n   = (state_n == ST_SHIFT);
        head_n       = (state_n == ST_SHIFT) && sreg_n[0];
        dout_valid_n = (state_n == ST_RESP);
        dout_data_n  = (state_n == ST_RESP) ? sreg_n : '0;
    end

    always_ff @(posedge SCLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_idx   <= '0;
            din_ready <= 1'b0;
            shift_en  <= 1'b0;
            head      <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            bit_idx   <= bit_idx_n;
            din_ready <= din_ready_n;
            shift_en  <= shift_en_n;
            head      <= head_n;
        end
    end

`ifdef CONFIG_SHIFTER_READBACK_EN
    logic              dout_valid;
    logic [BYTE_W-1:0] dout_data;

    always_ff @(posedge SCLK) begin
        if (!RESET) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            dout_valid <= dout_valid_n;
            dout_data  <= dout_data_n;
        end
    end

    assign DOUT_VALID = dout_valid;
    assign DOUT_DATA  = dout_data;
`else
    logic                unused_dout_valid_n;
    logic [BYTE_W-1:0]   unused_dout_data_n;
    assign unused_dout_valid_n = dout_valid_n;
    assign unused_dout_data_n  = dout_data_n;
    assign DOUT_VALID = 1'b0;
    assign DOUT_DATA  = '0;
`endif

    assign DIN_READY    = din_ready;
    assign SHIFT_ENABLE = shift_en;
    assign SHIFT_HEAD   = head;

    config_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CW        (CW)
    ) u_bit_counter (
        .clk    (SCLK),
        .rst_n  (RESET),
        .clear  (CLEAR),
        .shift  (shift_en),
        .count  (BIT_COUNT),
        .loaded (CHAIN_LOADED)
    );

endmodule

// File: tb/tb_config_shifter.sv
// Self-checking bench for config_shifter: attached 16-bit chain plus byte-level reference model.
module tb_config_shifter;

    localparam int CL = 16;
    localparam int unsigned CW = $clog2(CL + 1);
`ifdef CONFIG_SHIFTER_READBACK_EN
    localparam int PERIOD = 10;
`else
    localparam int PERIOD = 9;
`endif

    logic          SCLK;
    logic          RESET;
    logic          DIN_VALID;
    logic [7:0]    DIN_DATA;
    logic          DIN_READY;
    logic          DOUT_VALID;
    logic [7:0]    DOUT_DATA;
    logic          DOUT_READY;
    logic          SHIFT_ENABLE;
    logic          SHIFT_HEAD;
    logic          SHIFT_TAIL;
    logic          CLEAR;
    logic [CW-1:0] BIT_COUNT;
    logic          CHAIN_LOADED;

    config_shifter #(.CHAIN_LEN(CL)) dut (
        .SCLK         (SCLK),
        .RESET        (RESET),
        .DIN_VALID    (DIN_VALID),
        .DIN_DATA     (DIN_DATA),
        .DIN_READY    (DIN_READY),
        .DOUT_VALID   (DOUT_VALID),
        .DOUT_DATA    (DOUT_DATA),
        .DOUT_READY   (DOUT_READY),
        .SHIFT_ENABLE (SHIFT_ENABLE),
        .SHIFT_HEAD   (SHIFT_HEAD),
        .SHIFT_TAIL   (SHIFT_TAIL),
        .CLEAR        (CLEAR),
        .BIT_COUNT    (BIT_COUNT),
        .CHAIN_LOADED (CHAIN_LOADED)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    int cyc = 0;
    always @(posedge SCLK) cyc <= cyc + 1;

    // Physical chain attached to the loader: SIN enters at the top, SOUT is bit 0
    logic [15:0] chain;
    logic        chain_load;
    logic [15:0] chain_val;
    always @(posedge SCLK) begin
        if (chain_load) chain <= chain_val;
        else if (SHIFT_ENABLE) chain <= {SHIFT_HEAD, chain[15:1]};
    end
    assign SHIFT_TAIL = chain[0];

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_chain;
    int ref_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] preload);
        RESET      = 1'b0;
        chain_load = 1'b1;
        chain_val  = preload;
        tick();
        tick();
        chain_load = 1'b0;
        RESET      = 1'b1;
        tick();
        ref_chain = preload;
        ref_cnt   = 0;
    endtask

    task automatic check_idle();
        check("idle_ready", 32'(DIN_READY), 1);
        check("idle_ce", 32'(SHIFT_ENABLE), 0);
        check("idle_head", 32'(SHIFT_HEAD), 0);
        check("idle_dout_valid", 32'(DOUT_VALID), 0);
        check("bit_count", 32'(BIT_COUNT), 32'(ref_cnt));
        check("chain_loaded", 32'(CHAIN_LOADED), 32'(ref_cnt == CL));
        check("chain_contents", 32'(chain), 32'(ref_chain));
    endtask

    // One byte transaction; clear_at/abort_at select a CE cycle (0-based) or -1 for none
    task automatic send_byte(input logic [7:0] b, input int stall, input int clear_at,
                             input int abort_at, output int acc_cyc);
        int waited;
        logic [7:0] exp_rb;
        logic [23:0] cat;
        waited  = 0;
        exp_rb  = ref_chain[7:0];
        acc_cyc = -1;
        DIN_VALID = 1'b1;
        DIN_DATA  = b;
        while (!DIN_READY && waited < 40) begin
            tick();
            waited++;
        end
        check("accept_wait", 32'(waited < 40), 1);
        acc_cyc = cyc;
        tick();
        DIN_VALID = 1'b0;
        DIN_DATA  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("ce", 32'(SHIFT_ENABLE), 1);
            check("head", 32'(SHIFT_HEAD), 32'(b[i]));
            check("ready_in_shift", 32'(DIN_READY), 0);
            check("valid_in_shift", 32'(DOUT_VALID), 0);
            if (i == clear_at) CLEAR = 1'b1;
            if (i == abort_at) RESET = 1'b0;
            tick();
            CLEAR = 1'b0;
            if (i == abort_at) begin
                check("abort_ce", 32'(SHIFT_ENABLE), 0);
                check("abort_ready", 32'(DIN_READY), 0);
                check("abort_valid", 32'(DOUT_VALID), 0);
                check("abort_count", 32'(BIT_COUNT), 0);
                cat       = {b, ref_chain};
                ref_chain = 16'(cat >> (i + 1));
                ref_cnt   = 0;
                tick();
                RESET = 1'b1;
                tick();
                check_idle();
                return;
            end
        end
        if (clear_at >= 0) ref_cnt = 7 - clear_at;
        else ref_cnt = (ref_cnt + 8 > CL) ? CL : ref_cnt + 8;
        ref_chain = {b, ref_chain[15:8]};
        check("ce_done", 32'(SHIFT_ENABLE), 0);
        check("head_done", 32'(SHIFT_HEAD), 0);
`ifdef CONFIG_SHIFTER_READBACK_EN
        for (int s = 0; s < stall; s++) begin
            check("resp_valid_stall", 32'(DOUT_VALID), 1);
            check("resp_data_stall", 32'(DOUT_DATA), 32'(exp_rb));
            check("resp_ready_stall", 32'(DIN_READY), 0);
            tick();
        end
        check("resp_valid", 32'(DOUT_VALID), 1);
        check("resp_data", 32'(DOUT_DATA), 32'(exp_rb));
        DOUT_READY = 1'b1;
        tick();
        DOUT_READY = 1'b0;
        check("resp_data_cleared", 32'(DOUT_DATA), 0);
`else
        check("no_resp_data", 32'(DOUT_DATA), 0);
        repeat (stall) begin
            check("no_resp_valid", 32'(DOUT_VALID), 0);
            check("no_resp_ready", 32'(DIN_READY), 1);
            tick();
        end
`endif
        check_idle();
    endtask

    int t0, t1, t2;

    initial begin
        RESET      = 1'b0;
        DIN_VALID  = 1'b0;
        DIN_DATA   = 8'h00;
        DOUT_READY = 1'b0;
        CLEAR      = 1'b0;
        chain_load = 1'b1;
        chain_val  = 16'hBEEF;

        repeat (3) tick();
        check("rst_din_ready", 32'(DIN_READY), 0);
        check("rst_dout_valid", 32'(DOUT_VALID), 0);
        check("rst_ce", 32'(SHIFT_ENABLE), 0);
        check("rst_head", 32'(SHIFT_HEAD), 0);
        check("rst_dout_data", 32'(DOUT_DATA), 0);
        check("rst_loaded", 32'(CHAIN_LOADED), 0);
        check("rst_count", 32'(BIT_COUNT), 0);
        chain_load = 1'b0;
        RESET      = 1'b1;
        tick();
        check("post_rst_ready", 32'(DIN_READY), 1);
        check("post_rst_count", 32'(BIT_COUNT), 0);
        ref_chain = 16'hBEEF;
        ref_cnt   = 0;

        // Single byte: head bits 1,0,1,0,0,1,0,1 and readback 0xEF
        send_byte(8'hA5, 0, -1, -1, t0);
        check("single_count", 32'(BIT_COUNT), 8);

        // Two bytes with a stalled first response, then a saturating third byte
        do_reset(16'hBEEF);
        send_byte(8'h12, 5, -1, -1, t0);
        send_byte(8'h34, 0, -1, -1, t1);
        check("loaded_after_16", 32'(CHAIN_LOADED), 1);
        send_byte(8'h56, 0, -1, -1, t2);
        check("saturated_count", 32'(BIT_COUNT), 16);
        check("period", 32'(t2 - t1), 32'(PERIOD));

        // CLEAR on the 3rd CE cycle leaves 5 counted bits
        do_reset(16'h1234);
        send_byte(8'($urandom), 0, 2, -1, t0);
        check("clear_count", 32'(BIT_COUNT), 5);

        // Reset on the 4th CE cycle aborts the byte
        do_reset(16'hC3A5);
        send_byte(8'h5A, 0, -1, -1, t0);
        send_byte(8'h9C, 0, -1, 3, t0);

        // Randomized traffic against the reference model
        do_reset(16'($urandom));
        t1 = -1;
        for (int n = 0; n < 16; n++) begin
            int st, clr;
            st  = int'($urandom_range(0, 4));
            clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_byte(8'($urandom), st, clr, -1, t0);
        end
        // Back-to-back pair after random traffic
        send_byte(8'($urandom), 0, -1, -1, t1);
        send_byte(8'($urandom), 0, -1, -1, t2);
        check("period_random", 32'(t2 - t1), 32'(PERIOD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
